// File: rtl/fetch_ctrl_pkg.sv
// Shared definitions for the fetch/branch-resolution stage: FSM states,
// branch condition encodings and the assembler-generated target table.
package fetch_ctrl_pkg;

  typedef enum logic [1:0] {
    kIDLE = 2'd0,
    kRUN  = 2'd1,
    kDONE = 2'd2
  } fetch_state_e;

  localparam logic [1:0] kBR_ALWAYS = 2'b00;
  localparam logic [1:0] kBR_EQ     = 2'b01;
  localparam logic [1:0] kBR_NE     = 2'b10;
  localparam logic [1:0] kBR_LT     = 2'b11;

  // Populated branch targets; indices at or beyond kNumTargets read as 0.
  // Entries are stored wide and truncated to the PC width at lookup.
  localparam int kNumTargets = 8;
  localparam logic [15:0] kBranchTargets [kNumTargets] = '{
    16'd20, 16'd40, 16'd100, 16'd7, 16'd1023, 16'd512, 16'd3, 16'd300
  };

endpackage

// File: rtl/fetch_ctrl_branch_lut.sv
// Combinational branch-target lookup: TargetIdx -> program address.
module branch_lut
  import fetch_ctrl_pkg::*;
#(
  parameter int PC_W  = 10,
  parameter int LUT_W = 5
) (
  input  logic [LUT_W-1:0] target_idx,
  output logic [PC_W-1:0]  target
);

  // Match the index against each populated entry; unpopulated indices give 0.
  always_comb begin
    target = '0;
    for (int i = 0; i < kNumTargets; i++) begin
      if (target_idx == LUT_W'(i)) target = PC_W'(kBranchTargets[i]);
    end
  end

endmodule

// File: rtl/fetch_ctrl.sv
// Program counter, flag capture and branch resolution, plus the
// program-level start/halt handshake.
//   state | meaning
//   IDLE  | waiting for first Start after reset
//   RUN   | fetching/executing at ProgCtr
//   DONE  | halted, ProgCtr holds halt address, waiting for Start
module fetch_ctrl
  import fetch_ctrl_pkg::*;
#(
  parameter int PC_W  = 10,
  parameter int LUT_W = 5
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic             Stall,
  input  logic             Halt,
  input  logic             CmpEn,
  input  logic             ZeroIn,
  input  logic             NegIn,
  input  logic             BranchEn,
  input  logic [1:0]       BranchCond,
  input  logic [LUT_W-1:0] TargetIdx,
  output logic [PC_W-1:0]  ProgCtr,
  output logic             Fetch,
  output logic             Taken,
  output logic             FlagZ,
  output logic             FlagN,
  output logic             Done
);

  fetch_state_e state;
  logic [PC_W-1:0] target;
  logic cond_true;

  branch_lut #(.PC_W(PC_W), .LUT_W(LUT_W)) u_lut (
    .target_idx (TargetIdx),
    .target     (target)
  );

  // Branch condition evaluated against the registered flags only.
  always_comb begin
    cond_true = 1'b0;
    unique case (BranchCond)
      kBR_ALWAYS: cond_true = 1'b1;
      kBR_EQ:     cond_true = FlagZ;
      kBR_NE:     cond_true = ~FlagZ;
      kBR_LT:     cond_true = FlagN;
      default:    cond_true = 1'b0;
    endcase
  end

  // Status outputs decoded directly from state; stall and halt suppress a branch.
  always_comb begin
    Fetch = (state == kRUN);
    Done  = (state == kDONE);
    Taken = (state == kRUN) && !Stall && !Halt && BranchEn && cond_true;
  end

  // FSM with PC and flag registers.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state   <= kIDLE;
      ProgCtr <= '0;
      FlagZ   <= 1'b0;
      FlagN   <= 1'b0;
    end else begin
      unique case (state)
        kIDLE, kDONE: begin
          if (Start) begin
            state   <= kRUN;
            ProgCtr <= '0;
            FlagZ   <= 1'b0;
            FlagN   <= 1'b0;
          end
        end
        kRUN: begin
          if (!Stall) begin
            if (Halt) begin
              state <= kDONE;
            end else begin
              if (CmpEn) begin
                FlagZ <= ZeroIn;
                FlagN <= NegIn;
              end
              ProgCtr <= Taken ? target : ProgCtr + PC_W'(1);
            end
          end
        end
        default: state <= kIDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Self-checking bench for fetch_ctrl: directed test-plan scenarios followed
// by randomized stimulus against a behavioural model.
module tb_fetch_ctrl;

  logic       Clk = 1'b0;
  logic       Reset, Start, Stall, Halt, CmpEn, ZeroIn, NegIn, BranchEn;
  logic [1:0] BranchCond;
  logic [4:0] TargetIdx;
  logic [9:0] ProgCtr;
  logic       Fetch, Taken, FlagZ, FlagN, Done;

  fetch_ctrl #(.PC_W(10), .LUT_W(5)) dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .Stall(Stall), .Halt(Halt),
    .CmpEn(CmpEn), .ZeroIn(ZeroIn), .NegIn(NegIn), .BranchEn(BranchEn),
    .BranchCond(BranchCond), .TargetIdx(TargetIdx), .ProgCtr(ProgCtr),
    .Fetch(Fetch), .Taken(Taken), .FlagZ(FlagZ), .FlagN(FlagN), .Done(Done)
  );

  always #5 Clk = ~Clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: running/halted flags, program counter, flag pair.
  bit m_run, m_done, m_z, m_n;
  int m_pc;
  int tgt_tab [32];

  task automatic chk(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  function automatic bit cond_ok(input int c, input bit z, input bit n);
    case (c)
      0: return 1'b1;
      1: return z;
      2: return !z;
      default: return n;
    endcase
  endfunction

  task automatic model_reset();
    m_run = 0; m_done = 0; m_z = 0; m_n = 0; m_pc = 0;
  endtask

  task automatic check_outputs(input string tag, input bit exp_taken);
    chk({tag, ".pc"},    int'(ProgCtr), m_pc);
    chk({tag, ".fetch"}, int'(Fetch),   int'(m_run));
    chk({tag, ".done"},  int'(Done),    int'(m_done));
    chk({tag, ".flagz"}, int'(FlagZ),   int'(m_z));
    chk({tag, ".flagn"}, int'(FlagN),   int'(m_n));
    chk({tag, ".taken"}, int'(Taken),   int'(exp_taken));
  endtask

  // Called at posedge+1: drive, check before the next edge, advance model.
  task automatic do_cycle(input string tag, input bit st, input bit stl, input bit hl,
                          input bit cmp, input bit zi, input bit ni, input bit br,
                          input int cond, input int idx);
    bit tk;
    Start = st; Stall = stl; Halt = hl; CmpEn = cmp; ZeroIn = zi; NegIn = ni;
    BranchEn = br; BranchCond = 2'(cond); TargetIdx = 5'(idx);
    tk = m_run && !stl && !hl && br && cond_ok(cond, m_z, m_n);
    #3;
    check_outputs(tag, tk);
    @(posedge Clk);
    if (m_run) begin
      if (!stl) begin
        if (hl) begin
          m_run = 0; m_done = 1;
        end else begin
          if (cmp) begin m_z = zi; m_n = ni; end
          m_pc = tk ? tgt_tab[idx] : (m_pc + 1) % 1024;
        end
      end
    end else if (st) begin
      m_run = 1; m_done = 0; m_pc = 0; m_z = 0; m_n = 0;
    end
    #1;
  endtask

  task automatic idle_cycle(input string tag);
    do_cycle(tag, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // Asynchronous reset asserted mid-cycle; outputs must respond at once.
  task automatic mid_reset(input string tag);
    Reset = 1'b1;
    #1;
    model_reset();
    check_outputs(tag, 1'b0);
    @(posedge Clk);
    #1;
    Reset = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) tgt_tab[i] = 0;
    tgt_tab[0] = 20;   tgt_tab[1] = 40;   tgt_tab[2] = 100; tgt_tab[3] = 7;
    tgt_tab[4] = 1023; tgt_tab[5] = 512;  tgt_tab[6] = 3;   tgt_tab[7] = 300;

    Reset = 1'b1; Start = 0; Stall = 0; Halt = 0; CmpEn = 0; ZeroIn = 0;
    NegIn = 0; BranchEn = 0; BranchCond = 2'd0; TargetIdx = 5'd0;
    model_reset();
    @(posedge Clk); #1;
    check_outputs("reset", 1'b0);
    Reset = 1'b0;

    // Idle without Start stays idle; then Start pulse and linear fetch.
    idle_cycle("idle");
    do_cycle("start", 1, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) idle_cycle("linear");
    do_cycle("cmp_z", 0, 0, 0, 1, 1, 0, 0, 0, 0);
    chk("pc_at_branch", int'(ProgCtr), 4);
    do_cycle("br_eq", 0, 0, 0, 0, 0, 0, 1, 1, 2);
    chk("br_target", int'(ProgCtr), 100);

    // Same-cycle CMP + branch sees old (cleared) flags.
    do_cycle("cmp_clr", 0, 0, 0, 1, 0, 0, 0, 0, 0);
    do_cycle("cmp_br", 0, 0, 0, 1, 1, 0, 1, 1, 2);
    chk("cmp_br_pc", int'(ProgCtr), 102);
    chk("cmp_br_flagz", int'(FlagZ), 1);

    // Jump to 7, stall three cycles with a pending branch.
    do_cycle("br_to7", 0, 0, 0, 0, 0, 0, 1, 0, 3);
    for (int i = 0; i < 3; i++) do_cycle("stall", 0, 1, 0, 0, 0, 0, 1, 0, 0);
    chk("stall_pc", int'(ProgCtr), 7);
    idle_cycle("unstall");
    chk("unstall_pc", int'(ProgCtr), 8);

    // Unpopulated table index reads 0; jump to 1023 and wrap.
    do_cycle("br_empty", 0, 0, 0, 0, 0, 0, 1, 0, 20);
    do_cycle("br_to1023", 0, 0, 0, 0, 0, 0, 1, 0, 4);
    idle_cycle("wrap");
    chk("wrap_pc", int'(ProgCtr), 0);
    idle_cycle("after_wrap");

    // Halt beats branch and CMP; Done next cycle, PC held; Start restarts.
    do_cycle("halt_br", 0, 0, 1, 1, 1, 1, 1, 0, 0);
    chk("halt_done", int'(Done), 1);
    chk("halt_pc", int'(ProgCtr), 1);
    do_cycle("done_hold", 0, 0, 0, 0, 0, 0, 1, 0, 0);
    do_cycle("restart", 1, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("restart_pc", int'(ProgCtr), 0);
    for (int i = 0; i < 12; i++)
      do_cycle("to12", (i == 2), 0, 0, (i == 5), 0, 1, 0, 0, 0);
    chk("pc12", int'(ProgCtr), 12);
    chk("pc12_flagn", int'(FlagN), 1);
    mid_reset("midrst");
    idle_cycle("post_rst_idle");

    // Randomized phase.
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 299) == 0) begin
        mid_reset("rnd_rst");
      end else begin
        do_cycle("rnd",
                 ($urandom_range(0, 15) == 0),
                 ($urandom_range(0, 5) == 0),
                 ($urandom_range(0, 59) == 0),
                 ($urandom_range(0, 3) == 0),
                 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 3) == 0),
                 int'($urandom_range(0, 3)),
                 int'($urandom_range(0, 9)));
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
